ro_sweep_ctrl: RTL and testbench



---
 rtl/ro_pkg.sv | 20 ++
 rtl/ro_sweep_ctrl_if.sv | 33 +++
 rtl/ro_edge_counter.sv | 36 +++
 rtl/ro_sweep_ctrl.sv | 117 +++++++++++
 tb/tb_ro_sweep_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared types and constants for the ring-oscillator sweep controller
package ro_pkg;

  localparam int NUM_RO_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT,
    S_NEXT
  } ro_state_e;

  // Result tag: bank (0 = bank 1) sits directly above the oscillator index.
  function automatic int unsigned res_id_pack(input logic bank, input int unsigned idx,
                                              input int unsigned sel_w);
    return (32'(bank) << sel_w) | idx;
  endfunction

endpackage

// File: rtl/ro_sweep_ctrl_if.sv
// rtl/ro_sweep_ctrl_if.sv - control, oscillator and result signals of the sweep controller
interface ro_sweep_ctrl_if import ro_pkg::*; #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 12,
  parameter int NUM_RO = NUM_RO_DEF
) ();
  localparam int SEL_W = $clog2(NUM_RO);

  logic             start;
  logic [1:0]       bank_mask;
  logic [WIN_W-1:0] window;
  logic [3:0]       settle;
  logic             ro_tap;
  logic             res_ready;
  logic             ro_activate_1;
  logic             ro_activate_2;
  logic [SEL_W-1:0] ro_sel;
  logic             res_valid;
  logic [CNT_W-1:0] res_data;
  logic [SEL_W:0]   res_id;
  logic             busy;
  logic             done;

  modport master (
    output start, bank_mask, window, settle, ro_tap, res_ready,
    input  ro_activate_1, ro_activate_2, ro_sel, res_valid, res_data, res_id, busy, done
  );

  modport slave (
    input  start, bank_mask, window, settle, ro_tap, res_ready,
    output ro_activate_1, ro_activate_2, ro_sel, res_valid, res_data, res_id, busy, done
  );
endinterface

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - ro_tap synchroniser, rising-edge detector and saturating counter
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_tap_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_nxt_o
);
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // Stages 0/1 resynchronise; stage 2 only delays stage 1 for edge detection.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], ro_tap_i};
  end

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i && rise && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_nxt_o = cnt_d;
endmodule

// File: rtl/ro_sweep_ctrl.sv
// rtl/ro_sweep_ctrl.sv - sweeps both oscillator banks and reports one edge count per oscillator
module ro_sweep_ctrl import ro_pkg::*; #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 12,
  parameter int NUM_RO = NUM_RO_DEF
) (
  input logic            clk,
  input logic            rst,
  ro_sweep_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_RO);
  localparam int ID_W  = SEL_W + 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_RO - 1);
  localparam logic [WIN_W:0]   TMR_ONE  = (WIN_W + 1)'(1);

  ro_state_e        state_q, state_d;
  logic             both_q;
  logic [WIN_W-1:0] win_q;
  logic [3:0]       settle_q;
  logic [WIN_W-1:0] tmr_q;
  logic [WIN_W:0]   tmr_inc;
  logic             bank_q;
  logic [SEL_W-1:0] sel_q;
  logic [1:0]       act_q;
  logic             done_q;
  logic [CNT_W-1:0] res_data_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             settle_end, meas_end, last_sel, switch_bank;

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .ro_tap_i (bus.ro_tap),
    .clr_i    (state_q == S_SETTLE),
    .en_i     (state_q == S_MEASURE),
    .cnt_nxt_o(cnt_nxt)
  );

  // A zero length compares true on the first cycle, so 0 behaves as 1.
  assign tmr_inc     = {1'b0, tmr_q} + TMR_ONE;
  assign settle_end  = tmr_inc >= {{(WIN_W - 3){1'b0}}, settle_q};
  assign meas_end    = tmr_inc >= {1'b0, win_q};
  assign last_sel    = sel_q == SEL_LAST;
  assign switch_bank = !bank_q && both_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.start && bus.bank_mask != 2'b00) state_d = S_SETTLE;
      S_SETTLE:  if (settle_end) state_d = S_MEASURE;
      S_MEASURE: if (meas_end) state_d = S_REPORT;
      S_REPORT:  if (bus.res_ready) state_d = S_NEXT;
      S_NEXT:    state_d = (last_sel && !switch_bank) ? S_IDLE : S_SETTLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      both_q     <= 1'b0;
      win_q      <= '0;
      settle_q   <= '0;
      tmr_q      <= '0;
      bank_q     <= 1'b0;
      sel_q      <= '0;
      act_q      <= 2'b00;
      done_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      tmr_q  <= (state_d != state_q) ? '0 : tmr_inc[WIN_W-1:0];
      unique case (state_q)
        S_IDLE: if (state_d == S_SETTLE) begin
          both_q   <= &bus.bank_mask;
          win_q    <= bus.window;
          settle_q <= bus.settle;
          bank_q   <= !bus.bank_mask[0];
          sel_q    <= '0;
          act_q    <= bus.bank_mask[0] ? 2'b01 : 2'b10;
        end
        S_MEASURE: if (meas_end) res_data_q <= cnt_nxt;
        // Drop the bank while in NEXT so activates never overlap at a switch.
        S_REPORT: if (bus.res_ready && last_sel) act_q <= 2'b00;
        S_NEXT: begin
          if (!last_sel) begin
            sel_q <= sel_q + SEL_W'(1);
          end else if (switch_bank) begin
            bank_q <= 1'b1;
            sel_q  <= '0;
            act_q  <= 2'b10;
          end else begin
            done_q <= 1'b1;
            bank_q <= 1'b0;
            sel_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy          = state_q != S_IDLE;
    bus.res_valid     = state_q == S_REPORT;
    bus.done          = done_q;
    bus.ro_activate_1 = act_q[0];
    bus.ro_activate_2 = act_q[1];
    bus.ro_sel        = sel_q;
    bus.res_data      = res_data_q;
    bus.res_id        = ID_W'(res_id_pack(bank_q, 32'(sel_q), SEL_W));
  end
endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// tb/tb_ro_sweep_ctrl.sv - directed bench with a phase-level reference model for ro_sweep_ctrl
module tb_ro_sweep_ctrl;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 12;
  localparam int NUM_RO = 16;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ro_sweep_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W), .NUM_RO(NUM_RO)) bus ();

  ro_sweep_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .NUM_RO(NUM_RO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Oscillator stand-in: toggles every tap_half clocks, held low when 0.
  int tap_half = 0;
  int tap_cnt  = 0;
  always @(negedge clk) begin
    if (tap_half == 0) bus.ro_tap = 1'b0;
    else begin
      tap_cnt++;
      if (tap_cnt >= tap_half) begin
        tap_cnt = 0;
        bus.ro_tap = ~bus.ro_tap;
      end
    end
  end

  // Reference model: phase and remaining cycles of the oscillator being measured.
  typedef enum {P_IDLE, P_SET, P_MEAS, P_REP, P_NXT} ph_e;
  ph_e m_ph = P_IDLE;
  int  m_left, m_win, m_set, m_bank, m_sel, m_edges;
  bit  m_both, m_done, m_prev_tap;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_ph = P_IDLE; m_bank = 0; m_sel = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (bus.start && bus.bank_mask != 2'b00) begin
          m_win  = (bus.window == 0) ? 1 : int'(bus.window);
          m_set  = (bus.settle == 0) ? 1 : int'(bus.settle);
          m_both = bus.bank_mask == 2'b11;
          m_bank = bus.bank_mask[0] ? 0 : 1;
          m_sel  = 0; m_left = m_set; m_ph = P_SET;
        end
        P_SET: begin
          m_left--;
          if (m_left == 0) begin m_ph = P_MEAS; m_left = m_win; m_edges = 0; end
        end
        P_MEAS: begin
          if (bus.ro_tap && !m_prev_tap) m_edges++;
          m_left--;
          if (m_left == 0) m_ph = P_REP;
        end
        P_REP: if (bus.res_ready) m_ph = P_NXT;
        P_NXT: begin
          if (m_sel < NUM_RO - 1) begin m_sel++; m_left = m_set; m_ph = P_SET; end
          else if (m_bank == 0 && m_both) begin m_bank = 1; m_sel = 0; m_left = m_set; m_ph = P_SET; end
          else begin m_ph = P_IDLE; m_done = 1'b1; end
        end
        default: m_ph = P_IDLE;
      endcase
    end
    m_prev_tap = bus.ro_tap;
  end

  bit prev_valid = 1'b0;
  bit e_act;
  int e_data;
  int nbusy = 0, ndone = 0, nres = 0, first_id = -1;

  always begin
    @(posedge clk);
    #2;
    e_act = (m_ph == P_SET) || (m_ph == P_MEAS) || (m_ph == P_REP) ||
            (m_ph == P_NXT && m_sel != NUM_RO - 1);
    check("busy", bus.busy, m_ph != P_IDLE);
    check("act1", bus.ro_activate_1, e_act && m_bank == 0);
    check("act2", bus.ro_activate_2, e_act && m_bank == 1);
    check("res_valid", bus.res_valid, m_ph == P_REP);
    check("done", bus.done, m_done);
    if (m_ph != P_IDLE) check("ro_sel", bus.ro_sel, m_sel);
    if (m_ph == P_REP) begin
      check("res_id", bus.res_id, m_bank * NUM_RO + m_sel);
      e_data = (m_edges > SAT) ? SAT : m_edges;
      checks++;
      if (int'(bus.res_data) < e_data - 1 || int'(bus.res_data) > e_data + 1) begin
        errors++;
        $display("FAIL res_data: got %0d expected %0d+-1 at %0t", bus.res_data, e_data, $time);
      end
      if (first_id < 0) first_id = int'(bus.res_id);
    end
    if (prev_valid && bus.res_ready) nres++;
    nbusy += int'(bus.busy);
    ndone += int'(bus.done);
    prev_valid = bus.res_valid;
  end

  task automatic clear_counts();
    nbusy = 0; ndone = 0; nres = 0; first_id = -1;
  endtask

  task automatic start_sweep(input logic [1:0] mask, input int win, input int set);
    @(negedge clk);
    bus.bank_mask = mask;
    bus.window    = win[WIN_W-1:0];
    bus.settle    = set[3:0];
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen;
    int d0;
    seen = 1'b0;
    d0   = ndone;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = ndone != d0;
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = bus.res_valid;
    end
    check({name, "_valid_seen"}, seen, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.bank_mask = 2'b00; bus.window = '0; bus.settle = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_act", {bus.ro_activate_2, bus.ro_activate_1}, 0);
    check("rst_sel", bus.ro_sel, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_data", bus.res_data, 0);
    check("rst_id", bus.res_id, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;

    // Single bank, window 100, settle 2: 16 x (2+100+1+1) busy cycles.
    tap_half = 5; clear_counts();
    start_sweep(2'b01, 100, 2);
    check("t1_busy_at_k1", bus.busy, 1);
    check("t1_act1_at_k1", bus.ro_activate_1, 1);
    wait_done("t1", 2000);
    check("t1_busy_cycles", nbusy, 1664);
    check("t1_results", nres, 16);
    check("t1_done_pulses", ndone, 1);
    check("t1_first_id", first_id, 0);

    // Both banks, window 3, settle 1: 32 x 6 cycles.
    tap_half = 2; clear_counts();
    start_sweep(2'b11, 3, 1);
    wait_done("t2", 400);
    check("t2_busy_cycles", nbusy, 192);
    check("t2_results", nres, 32);
    check("t2_done_pulses", ndone, 1);

    // Backpressure on bank 2 only: first two reports held for 7 extra cycles.
    clear_counts(); bus.res_ready = 1'b0;
    start_sweep(2'b10, 5, 0);
    for (int r = 0; r < 2; r++) begin
      wait_valid("t3", 100);
      repeat (7) @(negedge clk);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
    end
    bus.res_ready = 1'b1;
    wait_done("t3", 400);
    check("t3_busy_cycles", nbusy, 142);
    check("t3_results", nres, 16);
    check("t3_first_id", first_id, 16);

    // Window 0 and settle 0 both behave as 1.
    clear_counts();
    start_sweep(2'b01, 0, 0);
    wait_done("t4", 200);
    check("t4_busy_cycles", nbusy, 64);

    // Empty bank mask: nothing happens.
    clear_counts();
    start_sweep(2'b00, 10, 1);
    repeat (10) @(negedge clk);
    check("t5_busy_cycles", nbusy, 0);
    check("t5_done_pulses", ndone, 0);

    // Start and new settings while busy are ignored.
    clear_counts();
    start_sweep(2'b01, 2, 1);
    repeat (20) @(negedge clk);
    bus.window = 12'd50; bus.settle = 4'd9; bus.bank_mask = 2'b11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t6", 400);
    check("t6_busy_cycles", nbusy, 80);
    check("t6_results", nres, 16);
    check("t6_done_pulses", ndone, 1);

    // Reset in the middle of the first measurement window.
    tap_half = 3; clear_counts();
    start_sweep(2'b11, 50, 2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_busy", bus.busy, 0);
    check("t7_act", {bus.ro_activate_2, bus.ro_activate_1}, 0);
    check("t7_valid", bus.res_valid, 0);
    check("t7_sel", bus.ro_sel, 0);
    check("t7_data", bus.res_data, 0);
    check("t7_done_pulses", ndone, 0);
    clear_counts();
    start_sweep(2'b01, 1, 0);
    wait_done("t7", 200);
    check("t7_first_id", first_id, 0);
    check("t7_busy_cycles", nbusy, 64);
    check("t7_results", nres, 16);

    // Counter saturation with a fast tap over the longest window.
    tap_half = 1; clear_counts();
    start_sweep(2'b01, 4095, 1);
    wait_valid("t8", 5000);
    check("t8_saturated", bus.res_data, SAT);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t8_busy_after_rst", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
